// File: rtl/lag_measure_controller_if.sv
// Handshake bundle between the lag-test sequencer and its neighbours:
// video timing, sensor input and the status/readout block.
interface lag_measure_controller_if #(
    parameter int CNT_WIDTH = 24
);
    logic                 enable;
    logic                 frame_start;
    logic                 sensor_in;
    logic                 flash;
    logic                 busy;
    logic                 sample_valid;
    logic [CNT_WIDTH-1:0] result_last;
    logic                 batch_valid;
    logic [CNT_WIDTH-1:0] result_avg;
    logic [CNT_WIDTH-1:0] result_min;
    logic [CNT_WIDTH-1:0] result_max;
    logic                 timeout_flag;

    modport master (
        output enable, frame_start, sensor_in,
        input  flash, busy, sample_valid, result_last,
        input  batch_valid, result_avg, result_min, result_max,
        input  timeout_flag
    );

    modport slave (
        input  enable, frame_start, sensor_in,
        output flash, busy, sample_valid, result_last,
        output batch_valid, result_avg, result_min, result_max,
        output timeout_flag
    );
endinterface

// File: rtl/lag_measure_controller.sv
// Input-lag test sequencer: settles on a dark screen, flashes a white box,
// times the sensor response and folds the latencies into batch statistics.
module lag_measure_controller #(
    parameter int          CNT_WIDTH     = 24,
    parameter int          LOG2_SAMPLES  = 4,
    parameter int          SETTLE_FRAMES = 8,
    parameter int          DEBOUNCE      = 16,
    parameter int unsigned TIMEOUT       = 4000000
) (
    input  logic clock,
    input  logic reset,
    lag_measure_controller_if.slave bus
);

    localparam int SAMPLES = 1 << LOG2_SAMPLES;
    localparam int ACC_W   = CNT_WIDTH + LOG2_SAMPLES;
    localparam int FRM_W   = $clog2(SETTLE_FRAMES + 1);
    localparam int RUN_W   = $clog2(DEBOUNCE + 1);
    localparam int IDX_W   = LOG2_SAMPLES + 1;
    localparam logic [CNT_WIDTH-1:0] LAT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [FRM_W-1:0]     FRM_LAST = FRM_W'(SETTLE_FRAMES - 1);
    localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(DEBOUNCE - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARM,
        S_MEASURE,
        S_RECORD
    } state_t;

    state_t               state_q, state_d;
    logic                 en_q;
    logic [FRM_W-1:0]     frm_q, frm_d;
    logic [CNT_WIDTH-1:0] lat_q, lat_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [CNT_WIDTH-1:0] first_hi_q, first_hi_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_WIDTH-1:0] min_q, min_d;
    logic [CNT_WIDTH-1:0] max_q, max_d;
    logic                 flash_q, flash_d;
    logic                 tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic [CNT_WIDTH-1:0] avg_q, avg_d;
    logic [CNT_WIDTH-1:0] rmin_q, rmin_d;
    logic [CNT_WIDTH-1:0] rmax_q, rmax_d;
    logic                 sv_q, sv_d;
    logic                 bv_q, bv_d;

    logic                 en_rise;
    logic                 hit;
    logic [ACC_W-1:0]     acc_sum;
    logic [CNT_WIDTH-1:0] min_new;
    logic [CNT_WIDTH-1:0] max_new;

    assign en_rise = bus.enable & ~en_q;
    assign acc_sum = acc_q + ACC_W'(first_hi_q);
    assign min_new = (first_hi_q < min_q) ? first_hi_q : min_q;
    assign max_new = (first_hi_q > max_q) ? first_hi_q : max_q;

    // Next-state and datapath updates for the measurement sequence.
    always_comb begin
        state_d    = state_q;
        frm_d      = frm_q;
        lat_d      = lat_q;
        run_d      = run_q;
        first_hi_d = first_hi_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        min_d      = min_q;
        max_d      = max_q;
        tmo_d      = tmo_q;
        last_d     = last_q;
        avg_d      = avg_q;
        rmin_d     = rmin_q;
        rmax_d     = rmax_q;
        sv_d       = 1'b0;
        bv_d       = 1'b0;
        hit        = 1'b0;

        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_rise) begin
                        tmo_d   = 1'b0;
                        acc_d   = '0;
                        idx_d   = '0;
                        min_d   = '1;
                        max_d   = '0;
                        frm_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.frame_start) begin
                        if (frm_q == FRM_LAST) begin
                            // A lit sensor here restarts the dark-frame count.
                            frm_d = '0;
                            if (!bus.sensor_in) begin
                                state_d = S_ARM;
                            end
                        end else begin
                            frm_d = frm_q + 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (bus.frame_start) begin
                        // The arming cycle is offset 0, so the first
                        // measuring cycle already reads 1.
                        lat_d   = CNT_WIDTH'(1);
                        run_d   = '0;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    lat_d = lat_q + 1'b1;
                    if (bus.sensor_in) begin
                        if (run_q == '0) begin
                            first_hi_d = lat_q;
                        end
                        run_d = run_q + 1'b1;
                        if (run_q == RUN_LAST) begin
                            hit     = 1'b1;
                            state_d = S_RECORD;
                        end
                    end else begin
                        run_d = '0;
                    end
                    if (!hit && lat_q == LAT_LAST) begin
                        tmo_d   = 1'b1;
                        frm_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
                S_RECORD: begin
                    last_d = first_hi_q;
                    sv_d   = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        avg_d  = CNT_WIDTH'(acc_sum >> LOG2_SAMPLES);
                        rmin_d = min_new;
                        rmax_d = max_new;
                        bv_d   = 1'b1;
                        acc_d  = '0;
                        idx_d  = '0;
                        min_d  = '1;
                        max_d  = '0;
                    end else begin
                        acc_d  = acc_sum;
                        idx_d  = idx_q + 1'b1;
                        min_d  = min_new;
                        max_d  = max_new;
                    end
                    frm_d   = '0;
                    state_d = S_SETTLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // The box stays drawn through the measurement and its record cycle.
        flash_d = (state_d == S_MEASURE) || (state_d == S_RECORD);
    end

    // State and result registers; reset drops the flash immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            frm_q      <= '0;
            lat_q      <= '0;
            run_q      <= '0;
            first_hi_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            min_q      <= '1;
            max_q      <= '0;
            flash_q    <= 1'b0;
            tmo_q      <= 1'b0;
            last_q     <= '0;
            avg_q      <= '0;
            rmin_q     <= '0;
            rmax_q     <= '0;
            sv_q       <= 1'b0;
            bv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= bus.enable;
            frm_q      <= frm_d;
            lat_q      <= lat_d;
            run_q      <= run_d;
            first_hi_q <= first_hi_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            min_q      <= min_d;
            max_q      <= max_d;
            flash_q    <= flash_d;
            tmo_q      <= tmo_d;
            last_q     <= last_d;
            avg_q      <= avg_d;
            rmin_q     <= rmin_d;
            rmax_q     <= rmax_d;
            sv_q       <= sv_d;
            bv_q       <= bv_d;
        end
    end

    assign bus.flash        = flash_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.sample_valid = sv_q;
    assign bus.result_last  = last_q;
    assign bus.batch_valid  = bv_q;
    assign bus.result_avg   = avg_q;
    assign bus.result_min   = rmin_q;
    assign bus.result_max   = rmax_q;
    assign bus.timeout_flag = tmo_q;

endmodule

// File: tb/tb_lag_measure_controller.sv
// Bench for lag_measure_controller: flash-level reference model with
// table vectors, hand-written corner sequences and random patterns.
module tb_lag_measure_controller;

    localparam int CW = 16;
    localparam int L2 = 2;
    localparam int SF = 2;
    localparam int DB = 4;
    localparam int TO = 1000;
    localparam int FP = 200;
    localparam int NB = 1 << L2;

    typedef struct {
        int hi;
        int g_at;
        int g_len;
        int light;
        int exp_lat;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    lag_measure_controller_if #(.CNT_WIDTH(CW)) bus ();

    lag_measure_controller #(
        .CNT_WIDTH    (CW),
        .LOG2_SAMPLES (L2),
        .SETTLE_FRAMES(SF),
        .DEBOUNCE     (DB),
        .TIMEOUT      (TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   fc = 0;
    int   meas_off = 0;
    int   settle_fs = 0;
    int   exp_settle = 3;
    int   light_h = 0;
    int   cur_exp = -1;
    int   sv_cnt = 0;
    int   bv_cnt = 0;
    int   fall_off = 0;
    logic flash_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic rose = 1'b0;
    logic fell = 1'b0;
    vec_t cur;
    int   q[$];
    vec_t tab[11];

    task automatic check(input string nm, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic bit sens(vec_t p, int k);
        return (p.hi > 0 && k >= p.hi) ||
               (k >= p.g_at && k < p.g_at + p.g_len);
    endfunction

    // First offset of a DEBOUNCE-long lit run inside the window, or -1.
    function automatic int model_lat(vec_t p);
        int run = 0;
        for (int k = 1; k < TO; k++) begin
            run = sens(p, k) ? run + 1 : 0;
            if (run == DB) return k - DB + 1;
        end
        return -1;
    endfunction

    task automatic cyc();
        longint s;
        int     mn;
        int     mx;
        @(posedge clock);
        #1;
        rose = bus.flash && !flash_prev;
        fell = !bus.flash && flash_prev;
        if (busy_prev && !flash_prev && bus.frame_start) settle_fs++;
        if (!bus.busy) settle_fs = 0;
        if (rose) begin
            check("flash_after_frame_start", bus.frame_start, 1);
            check("settle_frames", settle_fs, exp_settle);
            settle_fs = 0;
            meas_off = 1;
        end else begin
            meas_off++;
        end
        if (fell) fall_off = meas_off;
        if (bus.sample_valid) begin
            sv_cnt++;
            check("result_last", bus.result_last, cur_exp);
            q.push_back(cur_exp);
            check("batch_valid", bus.batch_valid, q.size() == NB);
            if (q.size() == NB) begin
                s = 0;
                mn = q[0];
                mx = q[0];
                foreach (q[i]) begin
                    s += q[i];
                    if (q[i] < mn) mn = q[i];
                    if (q[i] > mx) mx = q[i];
                end
                check("result_avg", bus.result_avg, s / NB);
                check("result_min", bus.result_min, mn);
                check("result_max", bus.result_max, mx);
                bv_cnt++;
                q.delete();
            end
        end else begin
            check("no_batch_valid", bus.batch_valid, 0);
        end
        flash_prev = bus.flash;
        busy_prev = bus.busy;
        fc = (fc + 1) % FP;
        bus.frame_start = (fc == 0);
        if (bus.flash) bus.sensor_in = sens(cur, meas_off);
        else if (bus.busy) bus.sensor_in = (settle_fs < light_h);
        else bus.sensor_in = 1'b0;
    endtask

    task automatic start_flash(input vec_t v, output bit ok);
        cur = v;
        light_h = v.light;
        exp_settle = SF * (v.light / SF + 1) + 1;
        cur_exp = (v.exp_lat == -2) ? model_lat(v) : v.exp_lat;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (rose) begin
                ok = 1'b1;
                break;
            end
        end
        check("flash_rise_seen", ok, 1);
    endtask

    task automatic run_flash(input vec_t v);
        bit ok;
        int n0;
        n0 = sv_cnt;
        start_flash(v, ok);
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            cyc();
            if (fell) begin
                ok = 1'b1;
                break;
            end
        end
        check("flash_fall_seen", ok, 1);
        if (cur_exp >= 0) begin
            check("sample_count", sv_cnt - n0, 1);
            check("flash_len", fall_off, cur_exp + DB + 1);
        end else begin
            check("sample_count", sv_cnt - n0, 0);
            check("flash_len", fall_off, TO);
            check("timeout_flag", bus.timeout_flag, 1);
        end
    endtask

    initial begin
        bit   ok;
        int   b0;
        vec_t v;

        tab = '{
            '{150, 0, 0, 0, 150},
            '{120, 50, 3, 0, 120},
            '{996, 0, 0, 0, 996},
            '{7, 0, 0, 0, 7},
            '{100, 0, 0, 0, 100},
            '{200, 0, 0, 0, 200},
            '{300, 0, 0, 0, 300},
            '{401, 0, 0, 0, 401},
            '{0, 0, 0, 0, -1},
            '{997, 0, 0, 0, -1},
            '{60, 0, 0, 3, 60}
        };
        cur = tab[0];

        bus.enable = 1'b0;
        bus.frame_start = 1'b0;
        bus.sensor_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_flash", bus.flash, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sample_valid", bus.sample_valid, 0);
        check("rst_batch_valid", bus.batch_valid, 0);
        check("rst_result_last", bus.result_last, 0);
        check("rst_result_avg", bus.result_avg, 0);
        check("rst_result_min", bus.result_min, 0);
        check("rst_result_max", bus.result_max, 0);
        check("rst_timeout_flag", bus.timeout_flag, 0);
        reset = 1'b0;
        cyc();

        bus.enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_flash(tab[i]);
            if (i == 7) begin
                check("batch2_avg", bus.result_avg, 250);
                check("batch2_min", bus.result_min, 100);
                check("batch2_max", bus.result_max, 401);
            end
        end
        check("timeout_sticky", bus.timeout_flag, 1);

        bus.enable = 1'b0;
        cyc();
        check("disable_busy", bus.busy, 0);
        check("disable_flag_holds", bus.timeout_flag, 1);
        q.delete();
        bus.enable = 1'b1;
        cyc();
        check("reenable_flag_clear", bus.timeout_flag, 0);
        check("reenable_busy", bus.busy, 1);

        v = '{80, 0, 0, 0, 80};
        run_flash(v);
        v = '{90, 0, 0, 0, 90};
        run_flash(v);
        v = '{0, 0, 0, 0, -1};
        start_flash(v, ok);
        repeat (30) cyc();
        bus.enable = 1'b0;
        cyc();
        check("abort_flash", bus.flash, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_last", bus.result_last, 90);
        check("abort_avg", bus.result_avg, 250);
        check("abort_min", bus.result_min, 100);
        check("abort_max", bus.result_max, 401);
        q.delete();
        bus.enable = 1'b1;
        b0 = bv_cnt;
        for (int i = 0; i < NB; i++) begin
            v = '{110 + 20 * i, 0, 0, 0, 110 + 20 * i};
            run_flash(v);
        end
        check("fresh_batch_count", bv_cnt - b0, 1);
        check("fresh_batch_avg", bus.result_avg, 140);

        for (int i = 0; i < 8; i++) begin
            v.hi = $urandom_range(999, 1);
            v.g_at = $urandom_range(900, 1);
            v.g_len = $urandom_range(3, 0);
            v.light = $urandom_range(3, 0);
            v.exp_lat = -2;
            run_flash(v);
        end

        v = '{0, 0, 0, 0, -1};
        start_flash(v, ok);
        repeat (10) cyc();
        reset = 1'b1;
        #1;
        check("midrst_flash", bus.flash, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_last", bus.result_last, 0);
        check("midrst_avg", bus.result_avg, 0);
        check("midrst_flag", bus.timeout_flag, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lag_measure_controller.md
Name: lag_measure_controller

Overview:
- Sequences the input-lag test on the time-sleuth board.
- Tells the video generator when to show the white flash box, timestamps the frame start and counts clock cycles until the photo sensor reports light.
- Accumulates per-flash latencies into batch statistics: last, average, min and max.
- Runs on the internal video clock, between the video timing generator (frame-start pulse), the synchronised SENSOR input and the status/readout logic.

Parameters:
- CNT_WIDTH, 24, width of the latency counter and of every result output.
- LOG2_SAMPLES, 4, batch size is 2**LOG2_SAMPLES flashes.
- SETTLE_FRAMES, 8, dark frames required before each flash.
- DEBOUNCE, 16, consecutive high sensor samples that count as a detection.
- TIMEOUT, 24'd4000000, cycles after flash start before the sample is abandoned.

Ports:
- clock  in  1  internal video clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  level; measurement runs while high.
- frame_start  in  1  one-cycle pulse at the first active line of each frame.
- sensor_in  in  1  synchronised sensor; 1 = light detected.
- flash  out  1  1 = video draws the white box.
- busy  out  1  state != IDLE.
- sample_valid  out  1  one-cycle pulse when result_last updates.
- result_last  out  CNT_WIDTH  latency of the most recent sample.
- batch_valid  out  1  one-cycle pulse when the batch results update.
- result_avg / result_min / result_max  out  CNT_WIDTH each  batch statistics.
- timeout_flag  out  1  sticky; set on any timeout, cleared on an enable rising edge.

Behaviour:
- Reset: all outputs are 0; state = IDLE; accumulator = 0; sample_idx = 0; running min = all-ones; running max = 0.
- States: IDLE, SETTLE, ARM, MEASURE, RECORD.
- IDLE:
  - flash = 0.
  - On an enable rising edge: clear timeout_flag, accumulator, sample_idx and the running min/max, then go to SETTLE.
- SETTLE:
  - flash = 0; count frame_start pulses.
  - After SETTLE_FRAMES pulses go to ARM, but only if sensor_in = 0 on the cycle of the last pulse.
  - If sensor_in = 1 at that point, restart the frame count; this guarantees a dark screen before the flash.
- ARM:
  - flash = 0; wait for frame_start.
  - On that cycle: flash <= 1, lat_cnt <= 0, go to MEASURE.
  - flash is registered, so the box is drawn from this frame on.
- MEASURE:
  - flash = 1; lat_cnt increments each cycle; the frame_start cycle counts as 0.
  - Further frame_start pulses are ignored.
  - Debounce: on the first high cycle of a run, latch first_hi = lat_cnt. A low cycle resets the run.
  - When the run reaches DEBOUNCE consecutive highs, capture first_hi and go to RECORD.
  - If lat_cnt == TIMEOUT-1 with no detection: set timeout_flag, flash <= 0, go to SETTLE; no sample is recorded and sample_idx is unchanged.
  - If detection and the timeout occur on the same cycle, detection wins.
- RECORD (1 cycle):
  - flash <= 0; result_last <= first_hi; sample_valid = 1.
  - accumulator += first_hi; accumulator width is CNT_WIDTH+LOG2_SAMPLES and never overflows.
  - Update running min/max; sample_idx++.
  - If sample_idx was 2**LOG2_SAMPLES-1 (the last sample of the batch):
    - result_avg <= (accumulator + first_hi) >> LOG2_SAMPLES (truncating).
    - result_min/result_max <= the updated running values; batch_valid = 1.
    - Then clear accumulator, sample_idx and the running min/max.
  - Then go to SETTLE.
- enable low in any state: next cycle state = IDLE, flash = 0, and the partial batch is discarded. result_* and timeout_flag hold their values.
- lat_cnt cannot exceed TIMEOUT-1, so no wrap. TIMEOUT must be <= 2**CNT_WIDTH.
- Reset asserted mid-measurement: flash drops asynchronously and all state returns to reset values.

Test Plan:
All scenarios use CNT_WIDTH=16, LOG2_SAMPLES=2, SETTLE_FRAMES=2, DEBOUNCE=4, TIMEOUT=1000, and frame_start every 200 cycles.
- Basic sample: enable; sensor goes high 150 cycles after the arming frame_start and stays high.
  -> flash high from the cycle after that frame_start; sample_valid pulse with result_last = 150; flash low after RECORD.
- Debounce: sensor glitches high for 3 cycles at offset 50, then high from offset 120.
  -> result_last = 120.
- Batch: four samples with latencies 100, 200, 300, 401.
  -> single batch_valid with result_avg = 250, result_min = 100, result_max = 401; no batch_valid after samples 1-3.
- Timeout: sensor stays low.
  -> at offset 999 flash drops, timeout_flag = 1, no sample_valid, and the next flash occurs after 2 more dark frames.
- Light during settle: sensor high through the settle frames.
  -> the controller stays in SETTLE with flash = 0 until the sensor reads low at a settle-complete frame_start.
- Abort: enable drops mid-MEASURE after 2 recorded samples.
  -> flash = 0 and busy = 0 the next cycle; results unchanged; re-enable then needs 4 fresh samples before batch_valid.
